// File: rtl/key_conditioner.sv
// key_conditioner
//   Input conditioning for raw push-button keys. Each key channel is
//   synchronised (2 flops), normalised to 1 = pressed, debounced and turned
//   into a one-cycle press strobe for the game FSM.
//
//   Optional feature: define KEY_AUTOREPEAT_EN to let keys in REPEAT_MASK
//   emit extra strobes while held (first after REPEAT_DELAY cycles, then
//   every REPEAT_PERIOD cycles). Without the macro the REPEAT_* parameters
//   do not exist and no repeat counters are built.
//
//   Reset is asserted asynchronously; its release is expected to be
//   synchronous to clk (provided by the system reset controller).
//
// Ports
//   clk        in   1      system clock
//   reset      in   1      asynchronous, active-high reset
//   key_raw    in   NKEYS  raw key pins, asynchronous to clk
//   key_level  out  NKEYS  debounced level, 1 = pressed (registered)
//   key_pulse  out  NKEYS  one-cycle strobe per accepted press (registered)
module key_conditioner #(
    parameter int unsigned      NKEYS         = 4,
    parameter int unsigned      DB_CYCLES     = 4,
    parameter bit               ACTIVE_LOW    = 1'b1
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int unsigned      REPEAT_DELAY  = 8,
    parameter int unsigned      REPEAT_PERIOD = 4,
    parameter logic [NKEYS-1:0] REPEAT_MASK   = NKEYS'(1)
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_raw,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] key_pulse
);

    localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [NKEYS-1:0] RELEASED = {NKEYS{ACTIVE_LOW}};

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } key_state_e;

    // Two-flop synchroniser, shared across all channels.
    logic [NKEYS-1:0] sync1_q, sync1_d;
    logic [NKEYS-1:0] sync2_q, sync2_d;
    logic [NKEYS-1:0] pressed_c;

    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= RELEASED;
            sync2_q <= RELEASED;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Polarity normalisation: 1 = pressed from here on.
    always_comb begin
        pressed_c = ACTIVE_LOW ? ~sync2_q : sync2_q;
    end

    for (genvar k = 0; k < NKEYS; k++) begin : g_key

        logic [DB_W-1:0] db_cnt_q, db_cnt_d;
        logic            level_q, level_d;
        logic            pulse_q, pulse_d;
        key_state_e      state_q, state_d;
`ifdef KEY_AUTOREPEAT_EN
        localparam bit REP_EN = REPEAT_MASK[k];
        logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

        // Debounce: level follows the synced input only after DB_CYCLES
        // consecutive mismatching cycles; any match restarts the count.
        always_comb begin
            db_cnt_d = '0;
            level_d  = level_q;
            if (pressed_c[k] != level_q) begin
                if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                    level_d = ~level_q;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
        end

        // Press FSM: strobe is generated from the next level so it lines up
        // with the edge at which key_level rises.
        always_comb begin
            state_d = state_q;
            pulse_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt_d = '0;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (level_d && !level_q) begin
                        state_d = ST_PRESSED;
                        pulse_d = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!level_d) begin
                        state_d = ST_IDLE;
`ifdef KEY_AUTOREPEAT_EN
                    end else if (REP_EN) begin
                        if (rep_cnt_q == REP_W'(REPEAT_DELAY - 1)) begin
                            state_d = ST_REPEAT;
                            pulse_d = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_W'(1);
                        end
`endif
                    end
                end
`ifdef KEY_AUTOREPEAT_EN
                ST_REPEAT: begin
                    if (!level_d) begin
                        state_d = ST_IDLE;
                    end else if (rep_cnt_q == REP_W'(REPEAT_PERIOD - 1)) begin
                        pulse_d = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                db_cnt_q <= '0;
                level_q  <= 1'b0;
                pulse_q  <= 1'b0;
                state_q  <= ST_IDLE;
            end else begin
                db_cnt_q <= db_cnt_d;
                level_q  <= level_d;
                pulse_q  <= pulse_d;
                state_q  <= state_d;
            end
        end

`ifdef KEY_AUTOREPEAT_EN
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rep_cnt_q <= '0;
            end else begin
                rep_cnt_q <= rep_cnt_d;
            end
        end
`endif

        assign key_level[k] = level_q;
        assign key_pulse[k] = pulse_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner (defaults: 4 keys, DB_CYCLES=4, active-low).
// Directed scenarios followed by random key activity; every cycle is
// compared against a window-based behavioural model.
module tb_key_conditioner;

    localparam int unsigned N  = 4;
    localparam int unsigned DB = 4;
`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned R_DELAY  = 8;
    localparam int unsigned R_PERIOD = 4;
    localparam logic [N-1:0] R_MASK  = 4'b0001;
`endif

    logic         clk;
    logic         reset;
    logic [N-1:0] key_raw;
    logic [N-1:0] key_level;
    logic [N-1:0] key_pulse;

    int vectors;
    int miscompares;

    key_conditioner dut (
        .clk       (clk),
        .reset     (reset),
        .key_raw   (key_raw),
        .key_level (key_level),
        .key_pulse (key_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw samples reach the debouncer two edges late; a
    // level change is accepted once the last DB synced samples all differ
    // from the current level.
    logic [N-1:0] raw_pipe[$];
    logic [N-1:0] syn_hist[$];
    logic [N-1:0] m_level;
    logic [N-1:0] m_pulse;
    int unsigned  hold_cnt[N];

    function automatic void model_reset();
        raw_pipe.delete();
        raw_pipe.push_back(4'hF);
        raw_pipe.push_back(4'hF);
        syn_hist.delete();
        m_level = '0;
        m_pulse = '0;
        for (int k = 0; k < int'(N); k++) hold_cnt[k] = 0;
    endfunction

    function automatic void model_edge();
        logic [N-1:0] s;
        logic [N-1:0] prev;
        bit           all_diff;
        if (reset) begin
            model_reset();
            return;
        end
        s = ~raw_pipe.pop_front();
        raw_pipe.push_back(key_raw);
        syn_hist.push_back(s);
        if (syn_hist.size() > int'(DB)) void'(syn_hist.pop_front());
        prev = m_level;
        for (int k = 0; k < int'(N); k++) begin
            if (syn_hist.size() == int'(DB)) begin
                all_diff = 1'b1;
                for (int i = 0; i < syn_hist.size(); i++)
                    if (syn_hist[i][k] == prev[k]) all_diff = 1'b0;
                if (all_diff) m_level[k] = ~prev[k];
            end
        end
        m_pulse = m_level & ~prev;
`ifdef KEY_AUTOREPEAT_EN
        for (int k = 0; k < int'(N); k++) begin
            if (m_level[k] && prev[k]) begin
                hold_cnt[k]++;
                if (R_MASK[k] && hold_cnt[k] >= R_DELAY &&
                    ((hold_cnt[k] - R_DELAY) % R_PERIOD) == 0)
                    m_pulse[k] = 1'b1;
            end else begin
                hold_cnt[k] = 0;
            end
        end
`endif
    endfunction

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock edge: update model, then compare away from the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_level", key_level, m_level);
        check("model_pulse", key_pulse, m_pulse);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int npulse;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        key_raw     = 4'hF;
        model_reset();

        // 1: async reset with no clock edge, then quiet after release
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("t1_rst_level", key_level, 4'b0000);
        check("t1_rst_pulse", key_pulse, 4'b0000);
        tick_n(2);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t1_idle_level", key_level, 4'b0000);
            check("t1_idle_pulse", key_pulse, 4'b0000);
        end

        // 2: single press held 12 cycles, then release
        key_raw = 4'hE;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_prepulse", key_pulse, 4'b0000);
        end
        tick();
        check("t2_pulse_e5", key_pulse, 4'b0001);
        check("t2_level_e5", key_level, 4'b0001);
        tick();
        check("t2_pulse_e6", key_pulse, 4'b0000);
        tick_n(5);
        key_raw = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_rel_hold", key_level, 4'b0001);
        end
        tick();
        check("t2_rel_level", key_level, 4'b0000);
        check("t2_rel_pulse", key_pulse, 4'b0000);
        tick_n(4);

        // 3: 3-cycle bounce on key 3 is rejected
        key_raw = 4'h7;
        tick_n(3);
        key_raw = 4'hF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_bounce_level", key_level, 4'b0000);
            check("t3_bounce_pulse", key_pulse, 4'b0000);
        end

        // 4: simultaneous press on keys 2 and 3
        key_raw = 4'h3;
        tick_n(5);
        tick();
        check("t4_dual_pulse", key_pulse, 4'b1100);
        check("t4_dual_level", key_level, 4'b1100);
        tick();
        check("t4_dual_after", key_pulse, 4'b0000);
        key_raw = 4'hF;
        tick_n(8);

        // 5: reset mid-hold on key 1, key still held afterwards
        key_raw = 4'hD;
        tick_n(9);
        check("t5_held_level", key_level, 4'b0010);
        reset = 1'b1;
        model_reset();
        #1;
        check("t5_async_level", key_level, 4'b0000);
        check("t5_async_pulse", key_pulse, 4'b0000);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_wait_pulse", key_pulse, 4'b0000);
        end
        tick();
        check("t5_repress_pulse", key_pulse, 4'b0010);
        key_raw = 4'hF;
        tick_n(8);

        // 6: long hold on key 0; repeat pulses only with the feature enabled
        key_raw = 4'hE;
        npulse  = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (key_pulse[0]) npulse++;
        end
`ifdef KEY_AUTOREPEAT_EN
        check("t6_pulse_count", 4'(npulse), 4'd6);
`else
        check("t6_pulse_count", 4'(npulse), 4'd1);
`endif
        key_raw = 4'hF;
        tick_n(10);

        // Random key activity with occasional resets
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < int'(N); k++)
                if ($urandom_range(0, 5) == 0) key_raw[k] = ~key_raw[k];
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                model_reset();
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
